// File: rtl/fifo_mac_ctrl.sv
// fifo_mac_ctrl: loads DEPTH operand pairs into twin FIFOs, drains them into a MAC.
// Build option MAC_SAT_EN: accumulator saturates instead of wrapping.
module fifo_mac_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_a,
  input  logic [DATA_WIDTH-1:0] load_b,
  output logic                  load_ready,
  output logic                  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_a_wdata,
  output logic [DATA_WIDTH-1:0] fifo_b_wdata,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_a_rdata,
  input  logic [DATA_WIDTH-1:0] fifo_b_rdata,
  input  logic                  fifo_a_empty,
  input  logic                  fifo_b_empty,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [ACC_WIDTH-1:0]    r_result;
  logic                    r_err;
  logic                    r_busy;
  logic                    r_done;

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_prod_ext;
  logic [ACC_WIDTH:0]      w_sum;
  logic [ACC_WIDTH-1:0]    w_acc_next;
  logic                    w_empty;

  assign load_ready   = (r_state == S_FILL) && (r_cnt < DEPTH_C);
  assign fifo_wren    = load_ready && load_valid;
  assign fifo_a_wdata = load_a;
  assign fifo_b_wdata = load_b;
  assign fifo_rden    = (r_state == S_DRAIN) && (r_cnt != '0);

  assign w_prod     = fifo_a_rdata * fifo_b_rdata;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_empty    = fifo_a_empty || fifo_b_empty;

`ifdef MAC_SAT_EN
  // Clamped acc plus any nonzero product carries out again, so it stays clamped.
  assign w_acc_next = w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FILL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_FILL: begin
          if (fifo_wren) begin
            r_cnt <= r_cnt + ONE_C;
            if (r_cnt == DEPTH_C - ONE_C)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_rden) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - ONE_C;
            if (w_empty)
              r_err <= 1'b1;
            if (r_cnt == ONE_C) begin
              r_result <= w_acc_next;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end
          end else begin
            r_result <= r_acc;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_mac_ctrl.md
Name: fifo_mac_ctrl

Overview:
- Sequencer for a pair of FIFO instances (A and B) feeding a multiply-accumulate.
- Accepts DEPTH operand pairs from a host load interface and writes them into both FIFOs in lockstep.
- Then drains both FIFOs together, accumulating sum(a*b) internally.
- Presents the final result with a one-cycle done pulse. Sits between the host/stimulus logic and the two FIFOs.

Parameters:
DEPTH, 8, operand pairs per job; must equal the attached FIFOs' depth
DATA_WIDTH, 8, operand width (unsigned)
ACC_WIDTH, 24, accumulator/result width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a job; sampled only in IDLE
load_valid  in  1  host operand pair valid
load_a  in  DATA_WIDTH  host operand A
load_b  in  DATA_WIDTH  host operand B
load_ready  out  1  controller accepts a pair this cycle
fifo_wren  out  1  write strobe to both FIFOs
fifo_a_wdata  out  DATA_WIDTH  write data to FIFO A
fifo_b_wdata  out  DATA_WIDTH  write data to FIFO B
fifo_rden  out  1  read strobe to both FIFOs
fifo_a_rdata  in  DATA_WIDTH  FIFO A output; valid combinationally in the cycle fifo_rden=1
fifo_b_rdata  in  DATA_WIDTH  FIFO B output; same timing as fifo_a_rdata
fifo_a_empty  in  1  FIFO A empty flag
fifo_b_empty  in  1  FIFO B empty flag
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when result becomes final
result  out  ACC_WIDTH  accumulated sum; held until next start
err  out  1  sticky: FIFO empty seen while the drain count is nonzero

Behaviour:
- Reset values: load_ready=0, fifo_wren=0, fifo_rden=0, busy=0, done=0, result=0, err=0, state=IDLE, cnt=0. Reset is asynchronous and may occur mid-job: abort immediately, no done pulse, FIFO contents are the FIFO's own concern.
- cnt: width $clog2(DEPTH)+1; counts pairs held in the FIFOs. The controller never relies on the FIFO full flag; cnt is authoritative.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - start=1 -> FILL; acc, result, err cleared to 0 on the same edge.
  - start in any other state is ignored.
- FILL:
  - load_ready=1 combinationally while cnt<DEPTH.
  - load_valid&&load_ready -> fifo_wren=1 (combinational, same cycle), fifo_a_wdata=load_a, fifo_b_wdata=load_b; cnt+1 at the edge.
  - The edge on which cnt reaches DEPTH moves to DRAIN.
  - load_valid with load_ready=0 is ignored (no write).
- DRAIN:
  - load_ready=0, fifo_wren=0 (never simultaneous with fifo_rden).
  - fifo_rden=1 every cycle while cnt>0.
  - Each read cycle: acc <= acc + fifo_a_rdata*fifo_b_rdata; cnt-1.
  - Product is 2*DATA_WIDTH unsigned, zero-extended/truncated to ACC_WIDTH; the sum wraps mod 2^ACC_WIDTH unless MAC_SAT_EN.
  - The edge on which cnt reaches 0 moves to DONE; result <= final acc on that edge.
  - If fifo_a_empty or fifo_b_empty=1 in a read cycle: err<=1 (sticky until next start), product still accumulated, sequence continues.
- DONE: done=1 for exactly one cycle; busy=1; then -> IDLE.
- Latency: start at cycle 0 with load_valid held high -> writes in cycles 1..DEPTH, reads in cycles DEPTH+1..2*DEPTH, done at cycle 2*DEPTH+1.
- result is stable from the DONE cycle until the next accepted start.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: any accumulate whose true sum exceeds 2^ACC_WIDTH-1 clamps acc to 2^ACC_WIDTH-1; it remains clamped for the rest of the job.
- Undefined: modular wrap.

Test Plan:
- Reset, start, load a=1..8, b=1 continuously -> fifo_wren high 8 cycles, fifo_rden high 8 cycles, done at cycle 17, result=36, err=0.
- a=b=3 for all 8 pairs, load_valid toggled every other cycle -> exactly 8 writes, load_ready low throughout DRAIN, result=72.
- start pulsed during FILL and DRAIN -> ignored, cnt and acc unaffected, single done pulse.
- rst_n asserted at 3rd DRAIN cycle -> all outputs 0 asynchronously, no done; a fresh job afterwards gives the correct result.
- ACC_WIDTH=16, a=b=255 x8 (true sum 520200) -> result=61448 without MAC_SAT_EN; 65535 with it.
- fifo_a_empty forced 1 in one DRAIN cycle -> err=1 held through done and IDLE; cleared on next start.
